axi_rd_slave_rom: RTL and testbench
===================================

AXI_RD_SLAVE_ROM -- requirements
Module: axi_rd_slave_rom

Interface
REQ-001 The module SHALL have parameter DEPTH_LOG2, default 10, giving log2 of the number of 32-bit words in the array.
REQ-002 The module SHALL have parameter INIT_LAT, default 2, giving the wait cycles from AR acceptance to the first R beat; legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 s_araddr  input  32  byte address of the first beat.
REQ-006 s_arlen  input  8  beats minus one.
REQ-007 s_arvalid  input  1  read request valid.
REQ-008 s_arready  output  1  request accepted when high together with s_arvalid.
REQ-009 s_rdata  output  32  read data beat.
REQ-010 s_rresp  output  2  response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-011 s_rlast  output  1  final beat of the burst.
REQ-012 s_rvalid  output  1  beat valid.
REQ-013 s_rready  input  1  initiator accepts the beat.
REQ-014 ld_wen  input  1  backdoor word write enable, for preload.
REQ-015 ld_addr  input  DEPTH_LOG2  backdoor word index.
REQ-016 ld_wdata  input  32  backdoor write data.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and BURST.
REQ-018 s_arready SHALL be 1 only in IDLE; s_arvalid&s_arready SHALL capture word index s_araddr[DEPTH_LOG2+1:2] and s_arlen; s_araddr[1:0] SHALL be ignored.
REQ-019 After acceptance the FSM SHALL go to WAIT for INIT_LAT cycles, then to BURST; with INIT_LAT=0 it SHALL go directly to BURST, so the first s_rvalid occurs 1 cycle after acceptance.
REQ-020 s_rdata SHALL come from an output register, loaded with mem[idx] on entry to BURST and with mem[idx+1] on each accepted beat.
REQ-021 In BURST, s_rvalid SHALL be 1 and a 8-bit beat counter SHALL count from 0.
REQ-022 s_rlast SHALL be 1 exactly when the beat counter equals the captured arlen.
REQ-023 A beat SHALL be accepted on s_rvalid&s_rready; on acceptance idx SHALL increment and the counter SHALL increment.
REQ-024 On acceptance of the s_rlast beat the FSM SHALL return to IDLE, with s_rvalid=0 and s_arready=1 the next cycle, so back-to-back bursts are separated by at least one IDLE cycle.
REQ-025 While s_rvalid=1 and s_rready=0, s_rdata, s_rresp and s_rlast SHALL hold stable.
REQ-026 idx SHALL wrap from 2^DEPTH_LOG2-1 to 0 within a burst.
REQ-027 arlen=0 SHALL produce a single beat with s_rlast=1.
REQ-028 arlen=255 SHALL produce 256 beats.
REQ-029 An ld_wen write SHALL update mem on the clock edge and be visible to any later register load.
REQ-030 An ld_wen write SHALL NOT alter a beat already held in the output register.
REQ-031 When ld_wen writes the word being loaded in the same cycle, the register SHALL receive the old value.
REQ-032 s_rready asserted outside BURST SHALL have no effect.
REQ-033 s_arvalid outside IDLE SHALL be ignored and not queued.

Reset
REQ-034 Asserting rst SHALL immediately force state IDLE, s_rvalid=0, s_rlast=0, s_rresp=2'b00, s_rdata=0, beat counter=0 and idx=0.
REQ-035 A burst interrupted by reset SHALL be abandoned without further beats.
REQ-036 After reset deasserts, s_arready SHALL be 1.
REQ-037 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-038 With AXI_RD_SLV_ERR_EN defined, a request whose s_araddr[31:DEPTH_LOG2+2] is nonzero SHALL still return arlen+1 beats, each with s_rresp=2'b10 and s_rdata=0.
REQ-039 Without AXI_RD_SLV_ERR_EN, address bits above DEPTH_LOG2+1 SHALL be ignored (aliasing) and s_rresp SHALL always be 2'b00.

Verification
REQ-040 Preload mem[8..15]=0x100..0x107; AR addr=0x20, len=7, rready=1, INIT_LAT=2 -> first rvalid 3 cycles after accept; data 0x100..0x107; rlast on beat 8.
REQ-041 AR addr=0x24, len=0 -> single beat 0x101 with rlast=1; then s_arready=1 on the next cycle.
REQ-042 len=7 with rready toggled 1,0,0,1,... -> rdata/rlast stable during stalls; sequence 0x100..0x107 intact, no beats lost or duplicated.
REQ-043 DEPTH_LOG2=10, AR addr=0xFF8, len=3 -> beats mem[1022], mem[1023], mem[0], mem[1].
REQ-044 Assert rst on beat 3 of a len=7 burst -> rvalid=0 in the same cycle; no further beats; a new AR is accepted after rst deasserts.
REQ-045 AR addr=0x0001_0000, len=1 -> with AXI_RD_SLV_ERR_EN: 2 beats with rresp=2'b10 and rdata=0; without it: mem[0], mem[1] with rresp=2'b00.

Source files
------------

// File: rtl/axi_rd_slave_rom.sv
// axi_rd_slave_rom: AXI read-only slave over a backdoor-loaded word array (optional AXI_RD_SLV_ERR_EN)
module axi_rd_slave_rom #(
  parameter int DEPTH_LOG2 = 10,
  parameter int INIT_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  input  logic                  ld_wen,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_wdata
);
  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
  state_t state, next;
  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] idx, ld_idx, ar_idx;
  logic [7:0] len, cnt;
  logic [3:0] wcnt;
  logic err, req_err, err_sel, accept, beat, last, load;
  logic unused;
  assign ar_idx = s_araddr[DEPTH_LOG2+1:2];
  assign unused = ^{s_araddr[1:0], s_araddr[31:DEPTH_LOG2+2]};
`ifdef AXI_RD_SLV_ERR_EN
  assign req_err = |s_araddr[31:DEPTH_LOG2+2];
`else
  assign req_err = 1'b0;
`endif
  assign s_arready = state == IDLE;
  assign s_rvalid = state == BURST;
  assign s_rlast = s_rvalid && last;
  assign accept = s_arready && s_arvalid;
  assign beat = s_rvalid && s_rready;
  assign last = cnt == len;
  // next state, and when/where the output register is reloaded
  always_comb begin
    next = state == IDLE ? (s_arvalid ? (INIT_LAT == 0 ? BURST : WAIT) : IDLE) :
           state == WAIT ? (wcnt == 4'd0 ? BURST : WAIT) :
           state == BURST ? (beat && last ? IDLE : BURST) : IDLE;
    load = (accept && INIT_LAT == 0) || (state == WAIT && wcnt == 4'd0) || (beat && !last);
    ld_idx = state == IDLE ? ar_idx : beat ? idx + 1'b1 : idx;
    err_sel = state == IDLE ? req_err : err;
  end
  // backdoor preload port; not touched by reset so contents survive it
  always_ff @(posedge clk)
    if (ld_wen) mem[ld_addr] <= ld_wdata;
  // burst control and output register; array read sees the pre-write word
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      len <= '0;
      cnt <= '0;
      wcnt <= '0;
      err <= 1'b0;
      s_rdata <= '0;
      s_rresp <= 2'b00;
    end else begin
      state <= next;
      if (accept) begin
        idx <= ar_idx;
        len <= s_arlen;
        cnt <= '0;
        err <= req_err;
        wcnt <= 4'(INIT_LAT - 1);
      end else if (state == WAIT) begin
        wcnt <= wcnt - 1'b1;
      end else if (beat) begin
        idx <= idx + 1'b1;
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        s_rdata <= err_sel ? 32'd0 : mem[ld_idx];
        s_rresp <= err_sel ? 2'b10 : 2'b00;
      end
    end
endmodule

// File: tb/tb_axi_rd_slave_rom.sv
// tb_axi_rd_slave_rom: directed checks of burst timing, data, stalls, wrap, reset and preload races
module tb_axi_rd_slave_rom;
  logic clk = 0, rst = 1;
  logic [31:0] s_araddr = 0, s_rdata, ld_wdata = 0;
  logic [7:0] s_arlen = 0;
  logic s_arvalid = 0, s_arready, s_rlast, s_rvalid, s_rready = 0, ld_wen = 0;
  logic [1:0] s_rresp;
  logic [9:0] ld_addr = 0;
  logic [31:0] got [0:255];
  logic gl [0:255];
  logic [1:0] gr [0:255];
  int tests = 0, fails = 0, n, lat;

  axi_rd_slave_rom #(.DEPTH_LOG2(10), .INIT_LAT(2)) dut (
    .clk(clk), .rst(rst), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .ld_wen(ld_wen), .ld_addr(ld_addr), .ld_wdata(ld_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(int a, logic [31:0] d);
    ld_wen = 1;
    ld_addr = 10'(a);
    ld_wdata = d;
    tick();
    ld_wen = 0;
  endtask

  task automatic rd(logic [31:0] a, logic [7:0] l, bit stall);
    int k;
    logic [31:0] hd;
    logic hl;
    s_araddr = a;
    s_arlen = l;
    s_arvalid = 1;
    s_rready = 0;
    chk("arready", 32'(s_arready), 1);
    tick();
    s_arvalid = 0;
    lat = 1;
    while (!s_rvalid && lat < 20) begin
      tick();
      lat++;
    end
    n = 0;
    k = 0;
    while (n <= int'(l) && k < 1000) begin
      s_rready = !stall || (k % 3 == 0);
      if (!s_rready) begin
        hd = s_rdata;
        hl = s_rlast;
        tick();
        chk("stall_data", s_rdata, hd);
        chk("stall_last", 32'(s_rlast), 32'(hl));
      end else begin
        if (s_rvalid) begin
          got[n] = s_rdata;
          gl[n] = s_rlast;
          gr[n] = s_rresp;
          n++;
        end
        tick();
      end
      k++;
    end
    s_rready = 0;
    chk("beats", n, 32'(l) + 1);
    chk("post_burst", {s_rvalid, s_arready}, 2'b01);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_rvalid", 32'(s_rvalid), 0);
    chk("rst_rlast", 32'(s_rlast), 0);
    chk("rst_rresp", 32'(s_rresp), 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_arready", 32'(s_arready), 1);
    for (int i = 0; i < 8; i++) ld(8 + i, 32'h100 + i);
    ld(1022, 32'hAAA);
    ld(1023, 32'hBBB);
    ld(0, 32'hC0);
    ld(1, 32'hC1);
    s_rready = 1;
    tick();
    tick();
    chk("idle_rready", {s_rvalid, s_arready}, 2'b01);
    rd(32'h20, 7, 0);
    chk("latency", lat, 3);
    for (int i = 0; i < 8; i++) begin
      chk("b1_data", got[i], 32'h100 + i);
      chk("b1_last", 32'(gl[i]), i == 7);
      chk("b1_resp", 32'(gr[i]), 0);
    end
    rd(32'h24, 0, 0);
    chk("single_data", got[0], 32'h101);
    chk("single_last", 32'(gl[0]), 1);
    rd(32'h20, 7, 1);
    for (int i = 0; i < 8; i++) begin
      chk("stall_seq", got[i], 32'h100 + i);
      chk("stall_seq_last", 32'(gl[i]), i == 7);
    end
    rd(32'hFF8, 3, 0);
    chk("wrap0", got[0], 32'hAAA);
    chk("wrap1", got[1], 32'hBBB);
    chk("wrap2", got[2], 32'hC0);
    chk("wrap3", got[3], 32'hC1);
    rd(32'h0001_0000, 1, 0);
`ifdef AXI_RD_SLV_ERR_EN
    chk("err_d0", got[0], 0);
    chk("err_d1", got[1], 0);
    chk("err_r0", 32'(gr[0]), 2);
    chk("err_r1", 32'(gr[1]), 2);
`else
    chk("alias_d0", got[0], 32'hC0);
    chk("alias_d1", got[1], 32'hC1);
    chk("alias_r0", 32'(gr[0]), 0);
    chk("alias_r1", 32'(gr[1]), 0);
`endif
    chk("last_of_2", 32'(gl[1]), 1);
    s_araddr = 32'h20;
    s_arlen = 7;
    s_arvalid = 1;
    tick();
    s_arvalid = 0;
    s_rready = 1;
    for (int k = 0; k < 10 && !s_rvalid; k++) tick();
    chk("rst_pre", s_rdata, 32'h100);
    tick();
    tick();
    chk("rst_beat3", s_rdata, 32'h102);
    rst = 1;
    #1;
    chk("rst_async_rvalid", 32'(s_rvalid), 0);
    chk("rst_async_rdata", s_rdata, 0);
    tick();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_nobeat", {s_rvalid, s_arready}, 2'b01);
    end
    rd(32'h28, 1, 0);
    chk("post_rst_d0", got[0], 32'h102);
    chk("post_rst_d1", got[1], 32'h103);
    s_araddr = 32'h20;
    s_arlen = 0;
    s_arvalid = 1;
    s_rready = 0;
    tick();
    s_arvalid = 0;
    tick();
    ld_wen = 1;
    ld_addr = 8;
    ld_wdata = 32'h777;
    tick();
    ld_wen = 0;
    chk("race_valid", 32'(s_rvalid), 1);
    chk("race_old", s_rdata, 32'h100);
    s_arvalid = 1;
    s_araddr = 32'h40;
    ld_wen = 1;
    ld_wdata = 32'h888;
    tick();
    ld_wen = 0;
    s_arvalid = 0;
    chk("held_after_ld", s_rdata, 32'h100);
    chk("held_last", 32'(s_rlast), 1);
    s_rready = 1;
    tick();
    s_rready = 0;
    chk("race_done", 32'(s_rvalid), 0);
    tick();
    chk("ar_not_queued", {s_rvalid, s_arready}, 2'b01);
    rd(32'h20, 0, 0);
    chk("ld_visible", got[0], 32'h888);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
